// File: rtl/wb_burst_if.sv
// Wishbone B3 master/slave bundle used between the burst engine and its slave.
// Ports: cyc/stb/we/addr/dat_o/sel/cti from master, ack/dat_i from slave.
interface wb_burst_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o,
        output wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o,
        input  wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one incrementing burst per command, pattern
// seed+k on writes, pattern check with error count on reads, per-beat timeout.
// Ports: wb_clk_i/wb_resetn, cmd_* request, wb (master modport), done_o,
// timeout_o (sticky), err_clr, err_cnt, first_err_addr.
module wb_burst_master #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LW  = 8,
    parameter int TMO = 1023
) (
    input  logic          wb_clk_i,
    input  logic          wb_resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_seed,
    wb_burst_if.master    wb,
    output logic          done_o,
    output logic          timeout_o,
    input  logic          err_clr,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_addr
);
    localparam int SW  = DW / 8;
    localparam int WCW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic            we_q;
    logic [LW-1:0]   len_q;
    logic [DW-1:0]   seed_q;
    logic [LW-1:0]   k_q;
    logic [WCW-1:0]  wcnt_q;
    logic            cyc_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   dat_q;
    logic [SW-1:0]   sel_q;
    logic [2:0]      cti_q;
    logic            tmo_q;
    logic [15:0]     err_q;
    logic [AW-1:0]   first_q;

    logic            accept;
    logic            ack_ev;
    logic            stall_out;
    logic            last;
    logic            mism;
    logic [LW-1:0]   k_nx;
    logic [DW-1:0]   exp_dat;

    assign last    = (k_q == len_q);
    assign k_nx    = k_q + 1'b1;
    assign exp_dat = seed_q + DW'(k_q);

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        ack_ev    = 1'b0;
        stall_out = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = S_BURST;
                end
            end
            S_BURST: begin
                if (wb.wb_ack_i) begin
                    ack_ev = 1'b1;
                    if (last) state_nx = S_DONE;
                end else if (wcnt_q == WCW'(TMO - 1)) begin
                    // TMO-th stalled cycle ends here: abort the rest
                    stall_out = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign mism = ack_ev & ~we_q & (wb.wb_dat_i != exp_dat);

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) state <= S_IDLE;
        else            state <= state_nx;
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            we_q   <= 1'b0;
            len_q  <= '0;
            seed_q <= '0;
            k_q    <= '0;
            wcnt_q <= '0;
            cyc_q  <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            cti_q  <= 3'b000;
        end else if (accept) begin
            we_q   <= cmd_we;
            len_q  <= cmd_len;
            seed_q <= cmd_seed;
            k_q    <= '0;
            wcnt_q <= '0;
            cyc_q  <= 1'b1;
            addr_q <= cmd_addr;
            dat_q  <= cmd_we ? cmd_seed : '0;
            sel_q  <= '1;
            cti_q  <= (cmd_len == '0) ? 3'b000 : 3'b010;
        end else if (ack_ev && !last) begin
            // present the next beat right away, no strobe gap
            k_q    <= k_nx;
            wcnt_q <= '0;
            addr_q <= addr_q + AW'(SW);
            dat_q  <= we_q ? (seed_q + DW'(k_nx)) : '0;
            cti_q  <= (k_nx == len_q) ? 3'b111 : 3'b010;
        end else if (ack_ev || stall_out) begin
            we_q   <= 1'b0;
            cyc_q  <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            cti_q  <= 3'b000;
        end else if (state == S_BURST) begin
            wcnt_q <= wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            err_q   <= '0;
            first_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (err_clr) begin
                // a mismatch in the clearing cycle is the first new error
                err_q   <= mism ? 16'd1 : 16'd0;
                first_q <= mism ? addr_q : '0;
            end else if (mism) begin
                if (err_q == 16'd0)     first_q <= addr_q;
                if (err_q != 16'hFFFF)  err_q   <= err_q + 16'd1;
            end
            if (stall_out)    tmo_q <= 1'b1;
            else if (err_clr) tmo_q <= 1'b0;
        end
    end

    assign cmd_ready      = (state == S_IDLE);
    assign done_o         = (state == S_DONE);
    assign timeout_o      = tmo_q;
    assign err_cnt        = err_q;
    assign first_err_addr = first_q;

    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = cyc_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_sel_o  = sel_q;
    assign wb.wb_cti_o  = cti_q;
endmodule
